// File: rtl/sd_cmd_frame.sv
// sd_cmd_frame: builds the 6-byte SPI-mode SD command frame and streams it over valid/ready.
// Define SD_SDHC_ADDR_EN for SDHC/SDXC block addressing; the default is SDSC byte addressing.
module sd_cmd_frame (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [15:0] address_in,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t      state;
    logic [2:0]  byte_idx;
    logic [6:0]  crc;
    logic [31:0] arg_r;
    logic [31:0] arg_in;
    logic [2:0]  nidx;
    logic [6:0]  crc_next;
    logic [7:0]  next_byte;

    function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] d);
        logic [6:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = d[i] ^ r[6];
            r  = {r[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return r;
    endfunction

`ifdef SD_SDHC_ADDR_EN
    assign arg_in = {16'h0000, address_in};
`else
    assign arg_in = {7'b0, address_in, 9'b0};
`endif

    // The byte currently on tx_byte is exactly B[byte_idx], so it feeds the CRC directly.
    always_comb begin
        nidx      = byte_idx + 3'd1;
        crc_next  = crc7_byte(crc, tx_byte);
        next_byte = nidx == 3'd1 ? arg_r[31:24] :
                    nidx == 3'd2 ? arg_r[23:16] :
                    nidx == 3'd3 ? arg_r[15:8]  :
                    nidx == 3'd4 ? arg_r[7:0]   : {crc_next, 1'b1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            byte_idx <= 3'd0;
            crc      <= 7'd0;
            arg_r    <= 32'd0;
            tx_byte  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= SEND;
                    arg_r    <= arg_in;
                    byte_idx <= 3'd0;
                    crc      <= 7'd0;
                    tx_byte  <= {2'b01, cmd_index};
                    tx_valid <= 1'b1;
                    busy     <= 1'b1;
                end
                SEND: if (byte_idx > 3'd5) begin
                    state    <= IDLE;
                    byte_idx <= 3'd0;
                    crc      <= 7'd0;
                    tx_byte  <= 8'h00;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end else if (tx_ready) begin
                    if (byte_idx == 3'd5) begin
                        state    <= DONE;
                        byte_idx <= 3'd0;
                        tx_byte  <= 8'h00;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        byte_idx <= nidx;
                        crc      <= crc_next;
                        tx_byte  <= next_byte;
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule
